inst_sequencer: RTL

Instruction issue unit that drives the 16-bit `code` input of the 4-bit CPU core. It holds a small loadable program memory and a program counter. Once started, it presents one instruction per clock, or a NOP, until it reaches a HALT word or the end of memory. It is the producer end of the CPU's instruction interface; the CPU consumes `code` combinationally on every clock.

---
 rtl/inst_sequencer_pkg.sv | 23 ++
 rtl/inst_sequencer_prog_mem.sv | 32 +++
 rtl/inst_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer slice.
//   state_t   : sequencer FSM states
//   OP_HALT   : opcode that terminates a program (never issued)
//   NOP_WORD  : instruction word the CPU decodes as no-write
//   OP_HI/LO  : opcode field bounds within a 16-bit instruction word
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]  OP_HALT  = 4'hE;
  localparam logic [15:0] NOP_WORD = 16'h0000;
  localparam int unsigned OP_HI    = 15;
  localparam int unsigned OP_LO    = 12;

  function automatic logic is_halt(input logic [15:0] word);
    return word[OP_HI:OP_LO] == OP_HALT;
  endfunction

endpackage

// File: rtl/inst_sequencer_prog_mem.sv
// Program memory for the instruction sequencer.
//   clk, clr : clock and synchronous active-high clear (all words -> 0)
//   we       : write enable for wdata -> mem[waddr]
//   raddr    : combinational read address, rdata = mem[raddr]
module prog_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_sequencer.sv
// Instruction issue unit feeding the 16-bit code input of the 4-bit CPU.
//   clk, clr            : clock, synchronous active-high reset (also clears memory)
//   load_en/addr/data   : program write port, honoured only outside RUN
//   start               : begin execution at address 0 (ignored if load_en)
//   hold                : stall, issue NOP with pc frozen
//   abort               : leave RUN and return to IDLE
//   code                : registered instruction presented to the CPU
//   busy / done         : state == RUN / state == DONE
//   issued              : instructions issued since the last start
module inst_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  input  logic          start,
  input  logic          hold,
  input  logic          abort,
  output logic [15:0]   code,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   issued
);

  state_t        state, state_nxt;
  logic [AW-1:0] pc;
  logic          wrapped;
  logic [15:0]   rd_word;
  logic          mem_we;
  logic          do_start;
  logic          do_issue;

  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .clr   (clr),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc),
    .rdata (rd_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (abort)                          state_nxt = IDLE;
        else if (hold)                      state_nxt = RUN;
        else if (wrapped || is_halt(rd_word)) state_nxt = DONE;
        else                                state_nxt = RUN;
      end
      default: begin
        if (start && !load_en) state_nxt = RUN;
        else if (abort)        state_nxt = IDLE;
      end
    endcase
  end

  // Output / control decode
  always_comb begin
    mem_we   = 1'b0;
    do_start = 1'b0;
    do_issue = 1'b0;
    if (state == RUN) begin
      do_issue = !abort && !hold && !wrapped && !is_halt(rd_word);
    end else begin
      mem_we   = load_en;
      do_start = start && !load_en;
    end
  end

  // Datapath: code is NOP on every edge that does not issue a word.
  // wrapped marks that the last address has been issued, so the pc
  // rolling over to 0 never re-issues mem[0].
  always_ff @(posedge clk) begin
    if (clr) begin
      pc      <= '0;
      wrapped <= 1'b0;
      issued  <= '0;
      code    <= NOP_WORD;
    end else begin
      code <= do_issue ? rd_word : NOP_WORD;
      if (do_start) begin
        pc      <= '0;
        wrapped <= 1'b0;
        issued  <= '0;
      end else if (do_issue) begin
        pc     <= pc + AW'(1);
        issued <= issued + (AW+1)'(1);
        if (pc == AW'(DEPTH-1)) wrapped <= 1'b1;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
